// File: rtl/pe_rf_pkg.sv
// Shared constants and helpers for the PE vector register file and its clients.
// The DEF_* values are the default geometry; the RF module re-derives widths from its own parameters.
package pe_rf_pkg;

  localparam int DEF_NUM_REGS   = 32;
  localparam int DEF_VEC_WIDTH  = 512;
  localparam int DEF_LANE_WIDTH = 32;
  localparam int DEF_NUM_RD     = 3;

  localparam int LANES  = DEF_VEC_WIDTH / DEF_LANE_WIDTH;
  localparam int AW     = $clog2(DEF_NUM_REGS);
  localparam int NUM_WR = 2;

  localparam int WP_ALU  = 0;
  localparam int WP_LOAD = 1;

  // Lane-granular merge: masked lanes take new_v, the rest keep old_v.
  function automatic logic [DEF_VEC_WIDTH-1:0] lane_merge(
    input logic [DEF_VEC_WIDTH-1:0] old_v,
    input logic [DEF_VEC_WIDTH-1:0] new_v,
    input logic [LANES-1:0]         mask
  );
    logic [DEF_VEC_WIDTH-1:0] res;
    res = old_v;
    for (int l = 0; l < LANES; l++) begin
      if (mask[l]) begin
        res[l*DEF_LANE_WIDTH +: DEF_LANE_WIDTH] = new_v[l*DEF_LANE_WIDTH +: DEF_LANE_WIDTH];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/vrf_scoreboard.sv
// Per-register busy scoreboard for RAW hazard tracking; alloc takes priority over a same-cycle clear.
// busy_next exposes the post-update view so read ports can bypass it.
module vrf_scoreboard
  import pe_rf_pkg::*;
#(
  parameter int  NUM_REGS  = DEF_NUM_REGS,
  parameter int  ZERO_REG0 = 1,
  localparam int ADDR_W    = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR-1:0]        wr_last,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  output logic [NUM_REGS-1:0]      busy_vec,
  output logic [NUM_REGS-1:0]      busy_next,
  output logic                     alloc_err
);

  localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W+1)'(NUM_REGS);

  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] clr_vec;
  logic                alloc_err_reg;
  logic                alloc_err_next;
  logic                alloc_ok;

  genvar gi, gw;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [NUM_WR-1:0] clr_hit;
      for (gw = 0; gw < NUM_WR; gw++) begin : g_port
        assign clr_hit[gw] = wr_en[gw] && wr_last[gw] &&
                             (wr_addr[gw*ADDR_W +: ADDR_W] == ADDR_W'(gi));
      end
      assign clr_vec[gi] = |clr_hit;

      if ((ZERO_REG0 != 0) && (gi == 0)) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_live
        assign busy_next[gi] = (alloc_en && (alloc_addr == ADDR_W'(gi))) ? 1'b1 :
                               (clr_vec[gi] ? 1'b0 : busy_reg[gi]);
      end
    end
  endgenerate

  assign alloc_ok = ({1'b0, alloc_addr} < REG_LIMIT) &&
                    !((ZERO_REG0 != 0) && (alloc_addr == '0));

  // Re-allocating a busy register is only an error when nothing retires it this cycle.
  assign alloc_err_next = alloc_en && alloc_ok && busy_reg[alloc_addr] && !clr_vec[alloc_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_reg      <= '0;
      alloc_err_reg <= 1'b0;
    end else begin
      busy_reg      <= busy_next;
      alloc_err_reg <= alloc_err_next;
    end
  end

  assign busy_vec  = busy_reg;
  assign alloc_err = alloc_err_reg;

endmodule

// File: rtl/vector_regfile_mp.sv
// Multi-ported lane-maskable vector register file: NUM_RD registered read ports with
// write-to-read bypass, two lane-masked write ports (port 1 wins per lane), busy scoreboard.
module vector_regfile_mp
  import pe_rf_pkg::*;
#(
  parameter int  NUM_REGS   = DEF_NUM_REGS,
  parameter int  VEC_WIDTH  = DEF_VEC_WIDTH,
  parameter int  LANE_WIDTH = DEF_LANE_WIDTH,
  parameter int  NUM_RD     = DEF_NUM_RD,
  parameter int  ZERO_REG0  = 1,
  localparam int N_LANES    = VEC_WIDTH / LANE_WIDTH,
  localparam int ADDR_W     = $clog2(NUM_REGS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_RD-1:0]           rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]    rd_addr,
  output logic [NUM_RD*VEC_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]           rd_busy,
  input  logic [NUM_WR-1:0]           wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]    wr_addr,
  input  logic [NUM_WR*N_LANES-1:0]   wr_mask,
  input  logic [NUM_WR*VEC_WIDTH-1:0] wr_data,
  input  logic [NUM_WR-1:0]           wr_last,
  input  logic                        alloc_en,
  input  logic [ADDR_W-1:0]           alloc_addr,
  output logic                        alloc_err,
  output logic [NUM_REGS-1:0]         busy_vec
);

  localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W+1)'(NUM_REGS);

  // Addresses that map onto real, writable storage (excludes v0 when hardwired to zero).
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < REG_LIMIT) && !((ZERO_REG0 != 0) && (a == '0));
  endfunction

  logic [VEC_WIDTH-1:0] mem [NUM_REGS];

  logic [ADDR_W-1:0]    wa [NUM_WR];
  logic [N_LANES-1:0]   wm [NUM_WR];
  logic [VEC_WIDTH-1:0] wd [NUM_WR];
  logic [NUM_WR-1:0]    wr_ok;
  logic [NUM_REGS-1:0]  busy_next;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WR; gi++) begin : g_wr
      assign wa[gi]    = wr_addr[gi*ADDR_W +: ADDR_W];
      assign wm[gi]    = wr_mask[gi*N_LANES +: N_LANES];
      assign wd[gi]    = wr_data[gi*VEC_WIDTH +: VEC_WIDTH];
      assign wr_ok[gi] = wr_en[gi] && addr_ok(wa[gi]);
    end
  endgenerate

  // Contents are not reset; a write coinciding with reset is dropped.
  // Port 1 is applied last, so its lanes override port 0 on an address collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_ok[w]) begin
          for (int l = 0; l < N_LANES; l++) begin
            if (wm[w][l]) begin
              mem[wa[w]][l*LANE_WIDTH +: LANE_WIDTH] <= wd[w][l*LANE_WIDTH +: LANE_WIDTH];
            end
          end
        end
      end
    end
  end

  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0]    ra;
      logic [VEC_WIDTH-1:0] rd_merged;
      logic                 busy_hit;
      logic [VEC_WIDTH-1:0] rd_data_reg;
      logic                 rd_busy_reg;

      assign ra = rd_addr[gi*ADDR_W +: ADDR_W];

      // Bypass: overlay this cycle's writes onto the stored value with the same lane priority.
      always_comb begin
        rd_merged = '0;
        busy_hit  = 1'b0;
        if (addr_ok(ra)) begin
          rd_merged = mem[ra];
          for (int w = 0; w < NUM_WR; w++) begin
            if (wr_ok[w] && (wa[w] == ra)) begin
              for (int l = 0; l < N_LANES; l++) begin
                if (wm[w][l]) begin
                  rd_merged[l*LANE_WIDTH +: LANE_WIDTH] = wd[w][l*LANE_WIDTH +: LANE_WIDTH];
                end
              end
            end
          end
          busy_hit = busy_next[ra];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_data_reg <= '0;
          rd_busy_reg <= 1'b0;
        end else if (rd_en[gi]) begin
          rd_data_reg <= rd_merged;
          rd_busy_reg <= busy_hit;
        end
      end

      assign rd_data[gi*VEC_WIDTH +: VEC_WIDTH] = rd_data_reg;
      assign rd_busy[gi]                        = rd_busy_reg;
    end
  endgenerate

  vrf_scoreboard #(
    .NUM_REGS  (NUM_REGS),
    .ZERO_REG0 (ZERO_REG0)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_last    (wr_last),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .busy_vec   (busy_vec),
    .busy_next  (busy_next),
    .alloc_err  (alloc_err)
  );

endmodule

// File: tb/tb_vector_regfile_mp.sv
// Directed bench for vector_regfile_mp: a register-level model is checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_vector_regfile_mp;

  localparam int NR  = 32;
  localparam int VW  = 512;
  localparam int NL  = 16;
  localparam int NP  = 3;
  localparam int AWB = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [NP-1:0]     rd_en;
  logic [NP*AWB-1:0] rd_addr;
  logic [NP*VW-1:0]  rd_data;
  logic [NP-1:0]     rd_busy;
  logic [1:0]        wr_en;
  logic [2*AWB-1:0]  wr_addr;
  logic [2*NL-1:0]   wr_mask;
  logic [2*VW-1:0]   wr_data;
  logic [1:0]        wr_last;
  logic              alloc_en;
  logic [AWB-1:0]    alloc_addr;
  logic              alloc_err;
  logic [NR-1:0]     busy_vec;

  always #5 clk = ~clk;

  vector_regfile_mp dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_mask    (wr_mask),
    .wr_data    (wr_data),
    .wr_last    (wr_last),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .alloc_err  (alloc_err),
    .busy_vec   (busy_vec)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] rdp(input int p);
    return rd_data[p*VW +: VW];
  endfunction

  // ---------------- reference model ----------------
  logic [VW-1:0] m_mem   [NR];
  bit            m_known [NR];
  bit            m_busy  [NR];
  bit            m_clr   [NR];
  logic [VW-1:0] e_rd    [NP];
  bit            e_known [NP];
  bit            e_rbusy [NP];
  bit            e_err;
  int            ma;

  initial begin
    for (int r = 0; r < NR; r++) begin
      m_known[r] = 1'b0;
      m_busy[r]  = 1'b0;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NP; p++) begin
        e_rd[p]    = '0;
        e_known[p] = 1'b1;
        e_rbusy[p] = 1'b0;
      end
      for (int r = 0; r < NR; r++) m_busy[r] = 1'b0;
      e_err = 1'b0;
    end else begin
      // register contents after this edge; port 1 lands last so it wins per lane
      for (int w = 0; w < 2; w++) begin
        if (wr_en[w]) begin
          ma = int'(wr_addr[w*AWB +: AWB]);
          if (ma != 0) begin
            if (wr_mask[w*NL +: NL] == 16'hFFFF) m_known[ma] = 1'b1;
            for (int l = 0; l < NL; l++)
              if (wr_mask[w*NL+l]) m_mem[ma][l*32 +: 32] = wr_data[w*VW + l*32 +: 32];
          end
        end
      end
      for (int r = 0; r < NR; r++) m_clr[r] = 1'b0;
      for (int w = 0; w < 2; w++)
        if (wr_en[w] && wr_last[w]) m_clr[int'(wr_addr[w*AWB +: AWB])] = 1'b1;
      e_err = 1'b0;
      ma = int'(alloc_addr);
      if (alloc_en && ma != 0 && m_busy[ma] && !m_clr[ma]) e_err = 1'b1;
      for (int r = 1; r < NR; r++) if (m_clr[r]) m_busy[r] = 1'b0;
      if (alloc_en && ma != 0) m_busy[ma] = 1'b1;
      // reads see the post-write, post-scoreboard state
      for (int p = 0; p < NP; p++) begin
        if (rd_en[p]) begin
          ma = int'(rd_addr[p*AWB +: AWB]);
          if (ma == 0) begin
            e_rd[p] = '0; e_known[p] = 1'b1; e_rbusy[p] = 1'b0;
          end else begin
            e_rd[p] = m_mem[ma]; e_known[p] = m_known[ma]; e_rbusy[p] = m_busy[ma];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [NR-1:0] eb;
    if (chk_en && !rst) begin
      for (int r = 0; r < NR; r++) eb[r] = m_busy[r];
      for (int p = 0; p < NP; p++) begin
        if (e_known[p]) chk($sformatf("model_rd_data%0d", p), rdp(p), e_rd[p]);
        chk($sformatf("model_rd_busy%0d", p), VW'(rd_busy[p]), VW'(e_rbusy[p]));
      end
      chk("model_busy_vec", VW'(busy_vec), VW'(eb));
      chk("model_alloc_err", VW'(alloc_err), VW'(e_err));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    rd_en = '0; wr_en = '0; wr_mask = '0; wr_last = '0; alloc_en = 1'b0;
  endtask

  task automatic set_wr(input int w, input int a, input logic [NL-1:0] m,
                        input logic [VW-1:0] d, input bit last);
    wr_en[w] = 1'b1;
    wr_addr[w*AWB +: AWB] = AWB'(a);
    wr_mask[w*NL +: NL]   = m;
    wr_data[w*VW +: VW]   = d;
    wr_last[w] = last;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_en[p] = 1'b1;
    rd_addr[p*AWB +: AWB] = AWB'(a);
  endtask

  task automatic set_alloc(input int a);
    alloc_en = 1'b1;
    alloc_addr = AWB'(a);
  endtask

  task automatic step();
    $display("txn t=%0t wr_en=%b wr_addr=%h wr_mask=%h wr_last=%b rd_en=%b rd_addr=%h alloc=%b@%0d",
             $time, wr_en, wr_addr, wr_mask, wr_last, rd_en, rd_addr, alloc_en, alloc_addr);
    @(posedge clk);
    #2;
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  localparam logic [VW-1:0] V5_EXP = {{15{32'hA5A5A5A5}}, 32'h00001234};

  int pool [8] = '{1, 2, 3, 4, 5, 6, 7, 9};
  logic [VW-1:0] rnd;

  initial begin
    rst = 1'b1;
    idle();
    rd_addr = '0; wr_addr = '0; wr_data = '0; alloc_addr = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // 1: reset state
    for (int p = 0; p < NP; p++) chk("reset_rd_data", rdp(p), '0);
    chk("reset_rd_busy", VW'(rd_busy), '0);
    chk("reset_busy_vec", VW'(busy_vec), '0);
    chk("reset_alloc_err", VW'(alloc_err), '0);
    chk_en = 1'b1;
    for (int p = 0; p < NP; p++) set_rd(p, 0);
    step();
    for (int p = 0; p < NP; p++) chk("read_v0_after_reset", rdp(p), '0);

    // 2: full write then single-lane patch from port 1
    set_wr(0, 5, 16'hFFFF, {16{32'hA5A5A5A5}}, 1'b0);
    step();
    set_wr(1, 5, 16'h0001, VW'(32'h1234), 1'b0);
    step();
    set_rd(0, 5);
    step();
    chk("t2_v5_merge", rdp(0), V5_EXP);

    // 3: simultaneous writes to v7 with same-cycle read (bypass + port-1 priority)
    set_wr(0, 7, 16'hFFFF, {VW{1'b1}}, 1'b0);
    set_wr(1, 7, 16'h00FF, '0, 1'b0);
    set_rd(1, 7);
    step();
    chk("t3_v7_bypass", rdp(1), {{256{1'b1}}, {256{1'b0}}});

    // 4: alloc, busy read, clear+alloc same cycle
    set_wr(0, 3, 16'hFFFF, {16{32'h33333333}}, 1'b0);
    step();
    set_alloc(3);
    step();
    set_rd(2, 3);
    step();
    chk("t4_rd_busy_v3", VW'(rd_busy[2]), VW'(1'b1));
    set_wr(0, 3, 16'hFFFF, {16{32'h44444444}}, 1'b1);
    set_alloc(3);
    set_rd(0, 3);
    step();
    chk("t4_busy_kept", VW'(busy_vec[3]), VW'(1'b1));
    chk("t4_no_err", VW'(alloc_err), VW'(1'b0));
    chk("t4_rd_busy_bypass", VW'(rd_busy[0]), VW'(1'b1));
    chk("t4_rd_data_bypass", rdp(0), {16{32'h44444444}});
    set_wr(1, 3, 16'h0000, '0, 1'b1);
    set_rd(0, 3);
    step();
    chk("t4_cleared", VW'(busy_vec[3]), VW'(1'b0));
    chk("t4_clear_bypass", VW'(rd_busy[0]), VW'(1'b0));
    chk("t4_mask0_no_write", rdp(0), {16{32'h44444444}});

    // 5: double alloc without clear
    set_wr(0, 9, 16'hFFFF, {16{32'h99999999}}, 1'b0);
    step();
    set_alloc(9);
    step();
    chk("t5_first_alloc_ok", VW'(alloc_err), VW'(1'b0));
    set_alloc(9);
    step();
    chk("t5_alloc_err", VW'(alloc_err), VW'(1'b1));
    chk("t5_busy9", VW'(busy_vec[9]), VW'(1'b1));
    step();
    chk("t5_err_pulse", VW'(alloc_err), VW'(1'b0));

    // 6: v0 is hardwired
    set_wr(0, 0, 16'hFFFF, {VW{1'b1}}, 1'b0);
    set_alloc(0);
    set_rd(0, 0);
    set_rd(1, 0);
    step();
    chk("t6_v0_data", rdp(0), '0);
    chk("t6_v0_rd_busy", VW'(rd_busy[0]), VW'(1'b0));
    chk("t6_v0_busy_vec", VW'(busy_vec[0]), VW'(1'b0));
    set_alloc(0);
    step();
    chk("t6_v0_no_err", VW'(alloc_err), VW'(1'b0));

    // async reset mid-stream; the write presented during reset must be lost
    set_alloc(12);
    step();
    chk("t6_busy12", VW'(busy_vec[12]), VW'(1'b1));
    set_wr(0, 5, 16'hFFFF, {16{32'h55555555}}, 1'b0);
    set_alloc(13);
    rst = 1'b1;
    #1;
    chk("t6_rst_busy_vec", VW'(busy_vec), '0);
    chk("t6_rst_alloc_err", VW'(alloc_err), '0);
    chk("t6_rst_rd_data", rdp(0), '0);
    @(posedge clk);
    #2;
    idle();
    rst = 1'b0;
    set_rd(0, 5);
    step();
    chk("t6_write_lost", rdp(0), V5_EXP);
    chk("t6_busy_after_rst", VW'(busy_vec), '0);

    // mixed traffic, checked cycle by cycle against the model
    set_wr(0, 1, 16'hFFFF, {16{32'h11111111}}, 1'b0);
    set_wr(1, 2, 16'hFFFF, {16{32'h22222222}}, 1'b0);
    step();
    set_wr(0, 4, 16'hFFFF, {16{32'h44440000}}, 1'b0);
    set_wr(1, 6, 16'hFFFF, {16{32'h66660000}}, 1'b0);
    step();
    for (int i = 0; i < 24; i++) begin
      for (int w = 0; w < 2; w++) begin
        if ($urandom_range(1, 0) == 1) begin
          for (int l = 0; l < NL; l++) rnd[l*32 +: 32] = $urandom;
          set_wr(w, pool[$urandom_range(7, 0)], NL'($urandom), rnd, bit'($urandom_range(1, 0)));
        end
      end
      for (int p = 0; p < NP; p++)
        if ($urandom_range(1, 0) == 1) set_rd(p, pool[$urandom_range(7, 0)]);
      if ($urandom_range(2, 0) == 0) set_alloc(pool[$urandom_range(7, 0)]);
      step();
    end
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
